// File: rtl/alu_operand_stage_if.sv
// Handshake bundle for the ALU operand stage.
// The upstream request and downstream adder operands travel together.
interface alu_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        carry_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [2:0]  out_op;

  modport master (
    output in_valid,
    output in_op,
    output in_x,
    output in_y,
    output carry_flag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  add_a,
    input  add_b,
    input  add_cin,
    input  out_op
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_x,
    input  in_y,
    input  carry_flag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output add_a,
    output add_b,
    output add_cin,
    output out_op
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Forms adder operands from an ALU opcode.
// A two-entry skid buffer keeps in_ready a pure flop output.
module alu_operand_stage (
  input  logic                clk,
  input  logic                rst,
  alu_operand_stage_if.slave  io
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [2:0]  op;
  } ent_t;

  state_e state_q, state_d;
  ent_t   main_q, main_d;
  ent_t   skid_q, skid_d;
  ent_t   new_ent;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  always_comb begin
    new_ent = '0;
    new_ent.op = io.in_op;
    unique case (io.in_op)
      3'b000: begin
        new_ent.a = io.in_x;
        new_ent.b = io.in_y;
        new_ent.cin = 1'b0;
      end
      3'b001: begin
        new_ent.a = io.in_x;
        new_ent.b = ~io.in_y;
        new_ent.cin = 1'b1;
      end
      3'b010: begin
        new_ent.a = io.in_x;
        new_ent.b = io.in_y;
        new_ent.cin = io.carry_flag;
      end
      3'b011: begin
        new_ent.a = io.in_x;
        new_ent.b = ~io.in_y;
        new_ent.cin = io.carry_flag;
      end
      3'b100: begin
        new_ent.a = io.in_x;
        new_ent.b = 32'h0;
        new_ent.cin = 1'b1;
      end
      3'b101: begin
        new_ent.a = io.in_x;
        new_ent.b = 32'hFFFF_FFFF;
        new_ent.cin = 1'b0;
      end
      3'b110: begin
        new_ent.a = 32'h0;
        new_ent.b = ~io.in_x;
        new_ent.cin = 1'b1;
      end
      3'b111: begin
        new_ent.a = io.in_x;
        new_ent.b = ~io.in_y;
        new_ent.cin = 1'b1;
      end
      default: new_ent = '0;
    endcase
  end

  // Reset forces in_ready low so nothing is taken that cycle
  assign io.in_ready = in_ready_q & ~rst;
  assign accept = io.in_valid & io.in_ready;
  assign drain  = io.out_valid & io.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = new_ent;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_d = new_ent;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = new_ent;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_comb begin
    io.out_valid = (state_q != EMPTY);
    io.add_a     = main_q.a;
    io.add_b     = main_q.b;
    io.add_cin   = main_q.cin;
    io.out_op    = main_q.op;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed checks of alu_operand_stage
// against a queue-based reference model.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [2:0]  op;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  ent_t q[$];

  alu_operand_stage_if bus();

  alu_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  logic [69:0] obs;
  assign obs = {bus.out_valid, bus.in_ready, bus.add_a,
                bus.add_b, bus.add_cin, bus.out_op};

  function automatic ent_t ref_op(input logic [2:0] op,
                                  input logic [31:0] x,
                                  input logic [31:0] y,
                                  input logic cf);
    ent_t e;
    e.op = op;
    case (op)
      3'd0: begin e.a = x;     e.b = y;            e.cin = 1'b0; end
      3'd1: begin e.a = x;     e.b = ~y;           e.cin = 1'b1; end
      3'd2: begin e.a = x;     e.b = y;            e.cin = cf;   end
      3'd3: begin e.a = x;     e.b = ~y;           e.cin = cf;   end
      3'd4: begin e.a = x;     e.b = 32'h0;        e.cin = 1'b1; end
      3'd5: begin e.a = x;     e.b = 32'hFFFFFFFF; e.cin = 1'b0; end
      3'd6: begin e.a = 32'h0; e.b = -x - 32'd1;   e.cin = 1'b1; end
      default: begin e.a = x;  e.b = ~y;           e.cin = 1'b1; end
    endcase
    return e;
  endfunction

  // Drive one cycle and advance the reference queue at the edge.
  task automatic step(input logic v, input logic [2:0] op,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic cf, input logic ordy);
    bit acc, drn;
    bus.in_valid   = v;
    bus.in_op      = op;
    bus.in_x       = x;
    bus.in_y       = y;
    bus.carry_flag = cf;
    bus.out_ready  = ordy;
    acc = v && !rst && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(ref_op(op, x, y, cf));
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, ordy);
  endtask

  task automatic test_reset;
    logic [69:0] exp;
    rst = 1'b1;
    idle(1'b1);
    step(1'b1, 3'd1, 32'h55, 32'h66, 1'b1, 1'b0);
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL reset_hold got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
    #1;
    exp = {1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 3'b000};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL reset_release got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_add;
    logic [69:0] exp;
    step(1'b1, 3'd0, 32'h5, 32'h3, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 32'h5, 32'h3, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL add_basic got=%h want=%h", obs, exp);
    end
    idle(1'b1);
    nvec++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL add_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_sub_neg;
    logic [69:0] exp;
    step(1'b1, 3'd1, 32'h10, 32'h1, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 32'h10, 32'hFFFFFFFE, 1'b1, 3'd1};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL sub got=%h want=%h", obs, exp);
    end
    step(1'b1, 3'd6, 32'h1, 32'h1234, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 32'h0, 32'hFFFFFFFE, 1'b1, 3'd6};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL neg got=%h want=%h", obs, exp);
    end
    idle(1'b1);
  endtask

  task automatic test_adc_hold;
    logic [69:0] exp;
    step(1'b1, 3'd2, 32'hA, 32'hB, 1'b1, 1'b0);
    exp = {1'b1, 1'b1, 32'hA, 32'hB, 1'b1, 3'd2};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL adc_accept got=%h want=%h", obs, exp);
    end
    step(1'b0, 3'd2, 32'hA, 32'hB, 1'b0, 1'b0);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL adc_hold got=%h want=%h", obs, exp);
    end
    idle(1'b1);
    nvec++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL adc_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_skid;
    logic [69:0] exp;
    step(1'b1, 3'd0, 32'h111, 32'h1, 1'b0, 1'b0);
    exp = {1'b1, 1'b1, 32'h111, 32'h1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL skid_r1 got=%h want=%h", obs, exp);
    end
    step(1'b1, 3'd0, 32'h222, 32'h2, 1'b0, 1'b0);
    exp = {1'b1, 1'b0, 32'h111, 32'h1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL skid_full got=%h want=%h", obs, exp);
    end
    step(1'b1, 3'd0, 32'h333, 32'h3, 1'b0, 1'b0);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL skid_r3_held got=%h want=%h", obs, exp);
    end
    step(1'b1, 3'd0, 32'h333, 32'h3, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 32'h222, 32'h2, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL skid_out_r2 got=%h want=%h", obs, exp);
    end
    step(1'b1, 3'd0, 32'h333, 32'h3, 1'b0, 1'b1);
    exp = {1'b1, 1'b1, 32'h333, 32'h3, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL skid_out_r3 got=%h want=%h", obs, exp);
    end
    idle(1'b1);
    nvec++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL skid_empty got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_stream;
    logic [2:0]  op;
    logic [31:0] x, y;
    logic        cf;
    ent_t        e;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      cf = 1'($urandom_range(0, 1));
      e  = ref_op(op, x, y, cf);
      step(1'b1, op, x, y, cf, 1'b1);
      nvec++;
      if (obs !== {1'b1, 1'b1, e}) begin
        nerr++;
        $display("FAIL stream_%0d got=%h want=%h", i, obs, {1'b1, 1'b1, e});
      end
    end
    idle(1'b1);
  endtask

  task automatic test_reset_mid;
    step(1'b1, 3'd0, 32'hDEAD, 32'h1, 1'b0, 1'b0);
    step(1'b1, 3'd0, 32'hBEEF, 32'h2, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 3'd0, 32'hCAFE, 32'h3, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    nvec++;
    if ({bus.out_valid, bus.in_ready, bus.add_a} !== {1'b0, 1'b1, 32'h0}) begin
      nerr++;
      $display("FAIL reset_mid got=%b %b %h want=0 1 0",
               bus.out_valid, bus.in_ready, bus.add_a);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      nvec++;
      if (bus.out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL reset_stale_%0d got=%b want=0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [69:0] exp;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0));
      exp[69] = (q.size() > 0);
      exp[68] = (q.size() < 2);
      exp[67:0] = (q.size() > 0) ? q[0] : obs[67:0];
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL random_%0d got=%h want=%h", i, obs, exp);
      end
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    nvec++;
    if (bus.out_valid !== 1'b0 || q.size() != 0) begin
      nerr++;
      $display("FAIL random_drain got=%b want=0", bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = 3'd0;
    bus.in_x       = 32'h0;
    bus.in_y       = 32'h0;
    bus.carry_flag = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_add();
    test_sub_neg();
    test_adc_hold();
    test_skid();
    test_stream();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
